// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and helpers for the writeback stage register file.
`default_nettype none

package mips_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 3'd0;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic data_t sat_inc(input data_t v);
    return (v == {DATA_W{1'b1}}) ? v : v + data_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_select.sv
// wb_select: writeback data mux and commit decode for the MEM/WB stage.
`default_nettype none

module wb_select
  import mips_pkg::*;
(
  input  logic      rst_n,
  input  logic      en,
  input  logic      reg_write,
  input  logic      mem_to_reg,
  input  reg_addr_t write_reg,
  input  data_t     mem_data,
  input  data_t     alu_result,
  output data_t     write_data,
  output logic      commit
);

  assign write_data = mem_to_reg ? mem_data : alu_result;
  // r0 is hardwired, so a write aimed at it never commits.
  assign commit     = en & reg_write & (write_reg != REG_ZERO) & rst_n;

endmodule

`default_nettype wire

// File: rtl/wb_register_file.sv
// wb_register_file: 8x16 register file with writeback commit and saturating write counter.
// Define WB_BYPASS_EN for write-through bypass on same-cycle reads of the committing index.
`default_nettype none

module wb_register_file
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              regWrite_out_pipe_4,
  input  logic              memtoReg_out_pipe_4,
  input  logic [2:0]        write_reg_ex_out_pipe_4,
  input  logic [DATA_W-1:0] data_mem_read_data_out_pipe_4,
  input  logic [DATA_W-1:0] aluResult_out_pipe_4,
  input  logic [2:0]        read_reg_1,
  input  logic [2:0]        read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_commit,
  output logic [DATA_W-1:0] wb_count
);

  data_t regs [NUM_REGS];
  data_t count_r;

  wb_select u_wb_select (
    .rst_n      (rst_n),
    .en         (en),
    .reg_write  (regWrite_out_pipe_4),
    .mem_to_reg (memtoReg_out_pipe_4),
    .write_reg  (write_reg_ex_out_pipe_4),
    .mem_data   (data_mem_read_data_out_pipe_4),
    .alu_result (aluResult_out_pipe_4),
    .write_data (wb_write_data),
    .commit     (wb_commit)
  );

  // wb_commit already folds in en, rst_n and the r0 guard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      count_r <= '0;
    end else if (wb_commit) begin
      regs[write_reg_ex_out_pipe_4] <= wb_write_data;
      count_r                       <= sat_inc(count_r);
    end
  end

  function automatic data_t read_port(input reg_addr_t idx);
    data_t v;
    v = (idx == REG_ZERO) ? '0 : regs[idx];
`ifdef WB_BYPASS_EN
    if (idx != REG_ZERO && wb_commit && idx == write_reg_ex_out_pipe_4) begin
      v = wb_write_data;
    end
`endif
    return v;
  endfunction

  always_comb begin
    read_data_1 = read_port(read_reg_1);
    read_data_2 = read_port(read_reg_2);
  end

  assign wb_count = count_r;

endmodule

`default_nettype wire

// File: tb/tb_wb_register_file.sv
// tb_wb_register_file: directed vector table, randomized model comparison, saturation and reset-priority checks.
`default_nettype none

module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        rst_n, en, regw, m2r;
  logic [2:0]  dest, rr1, rr2;
  logic [15:0] mem, alu;
  logic [15:0] rd1, rd2, wdata, cnt;
  logic        commit;

  int total = 0;
  int bad   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_register_file dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .en                            (en),
    .regWrite_out_pipe_4           (regw),
    .memtoReg_out_pipe_4           (m2r),
    .write_reg_ex_out_pipe_4       (dest),
    .data_mem_read_data_out_pipe_4 (mem),
    .aluResult_out_pipe_4          (alu),
    .read_reg_1                    (rr1),
    .read_reg_2                    (rr2),
    .read_data_1                   (rd1),
    .read_data_2                   (rd2),
    .wb_write_data                 (wdata),
    .wb_commit                     (commit),
    .wb_count                      (cnt)
  );

  // Reference model: plain array plus counter, updated from the rules after each edge.
  logic [15:0] m_regs [8];
  int          m_cnt = 0;

  function automatic logic m_commit();
    return rst_n && en && regw && (dest != 3'd0);
  endfunction

  function automatic logic [15:0] m_wd();
    return m2r ? mem : alu;
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] idx);
    if (idx == 3'd0) return 16'h0000;
    if (BYP && m_commit() && idx == dest) return m_wd();
    return m_regs[idx];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_cnt = 0;
    end else if (m_commit()) begin
      m_regs[dest] = m_wd();
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic w, input logic m,
                       input logic [2:0] d, input logic [15:0] md, input logic [15:0] ad,
                       input logic [2:0] a1, input logic [2:0] a2);
    @(negedge clk);
    rst_n = r; en = e; regw = w; m2r = m; dest = d; mem = md; alu = ad; rr1 = a1; rr2 = a2;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
  endtask

  typedef struct {
    logic        r, e, w, m;
    logic [2:0]  d;
    logic [15:0] md, ad;
    logic [2:0]  a1, a2;
    logic [15:0] x_rd1, x_rd2, x_wd;
    logic        x_cm;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vt [13];

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    rst_n = 1'b0; en = 1'b0; regw = 1'b0; m2r = 1'b0; dest = 3'd0;
    mem = 16'h0; alu = 16'h0; rr1 = 3'd0; rr2 = 3'd0;

    //         r     e     w     m     d     md        ad        a1    a2    rd1       rd2       wd        cm    cnt
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1111, 3'd0, 3'd1, 16'h0000, 16'h0000, 16'h1111, 1'b0, 16'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h2222, 16'h1111, 3'd2, 3'd3, 16'h0000, 16'h0000, 16'h2222, 1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd4, 3'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd6, 3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h9999, 16'h1234, 3'd1, 3'd2, 16'h0000, 16'h0000, 16'h1234, 1'b1, 16'd0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000, 16'h0000, 3'd3, 3'd3, 16'h1234, 16'h1234, 16'h0000, 1'b0, 16'd1};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h0F0F, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'hBEEF, 1'b1, 16'd1};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 3'd5, 3'd0, 16'hBEEF, 16'h0000, 16'hFFFF, 1'b0, 16'd2};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd5, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 16'd2};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0000, 16'h00AA, 3'd2, 3'd5, 16'h0000, 16'hBEEF, 16'h00AA, 1'b0, 16'd2};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000, 16'h0000, 3'd2, 3'd4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd2};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0000, 16'h5555, 3'd4, 3'd4,
               BYP ? 16'h5555 : 16'h0000, BYP ? 16'h5555 : 16'h0000, 16'h5555, 1'b1, 16'd2};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0000, 16'h0000, 3'd4, 3'd4, 16'h5555, 16'h5555, 16'h0000, 1'b0, 16'd3};

    // Two reset cycles with a write pending: commit must stay low.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 16'h7777, 3'd3, 3'd3);
      chk("reset_commit", {15'd0, commit}, 16'h0000);
      chk("reset_wdata_mux", wdata, 16'h7777);
      finish_cycle();
    end

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].r, vt[i].e, vt[i].w, vt[i].m, vt[i].d, vt[i].md, vt[i].ad, vt[i].a1, vt[i].a2);
      chk($sformatf("vec%0d_rd1", i), rd1, vt[i].x_rd1);
      chk($sformatf("vec%0d_rd2", i), rd2, vt[i].x_rd2);
      chk($sformatf("vec%0d_wdata", i), wdata, vt[i].x_wd);
      chk($sformatf("vec%0d_commit", i), {15'd0, commit}, {15'd0, vt[i].x_cm});
      chk($sformatf("vec%0d_count", i), cnt, vt[i].x_cnt);
      finish_cycle();
    end

    // Randomized traffic against the model, with occasional reset and stall.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0), 1'($urandom),
            1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
      chk("rand_rd1", rd1, m_rd(rr1));
      chk("rand_rd2", rd2, m_rd(rr2));
      chk("rand_wdata", wdata, m_wd());
      chk("rand_commit", {15'd0, commit}, {15'd0, m_commit()});
      chk("rand_count", cnt, 16'(m_cnt));
      finish_cycle();
    end

    // Drive the counter up to 16'hFFFE with commits to r1.
    while (m_cnt < 16'hFFFE) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 16'(m_cnt), 3'd0, 3'd0);
      finish_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd1, 3'd0);
    chk("preload_count", cnt, 16'hFFFE);
    chk("preload_r1", rd1, 16'hFFFD);
    finish_cycle();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 16'h0000, 16'hA5A5, 3'd0, 3'd0);
      finish_cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0000, 16'h0000, 3'd6, 3'd0);
      chk("sat_count", cnt, 16'hFFFF);
      chk("sat_r6", rd1, 16'hA5A5);
      finish_cycle();
    end

    // Reset wins over a simultaneous commit to r6.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 16'h0000, 16'h1357, 3'd6, 3'd0);
    chk("rstpri_commit", {15'd0, commit}, 16'h0000);
    finish_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 16'h2468, 16'h0000, 3'd6, 3'd1);
    chk("rstpri_r6", rd1, 16'h0000);
    chk("rstpri_r1", rd2, 16'h0000);
    chk("rstpri_count", cnt, 16'h0000);
    finish_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 16'h0000, 16'h0000, 3'd7, 3'd6);
    chk("postrst_r7", rd1, 16'h2468);
    chk("postrst_r6", rd2, 16'h0000);
    chk("postrst_count", cnt, 16'h0001);
    finish_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
